axis_frame_preamble_gen: RTL and testbench
==========================================

Name: axis_frame_preamble_gen

Overview:
Parametrised AXI-Stream framer that prefixes each packet with a runtime-selectable number of preamble words and a start-of-frame delimiter (SFD). It optionally appends a CRC-8 trailer and enforces a minimum inter-frame idle gap. It sits between the packet source and the Manchester encoder/serialiser on the transmit path. It sustains one output beat per clock with no bubbles between the preamble, SFD, data and CRC phases.

Parameters:
DATA_WIDTH, 8, word width; must be a multiple of 8
PREAMBLE_PATTERN, 8'hAA replicated to DATA_WIDTH, word emitted for every preamble beat
SFD_WORD, 8'hD5 zero-extended to DATA_WIDTH, delimiter emitted after the preamble
CNT_W, 4, width of cfg_preamble_len
APPEND_CRC, 0, 1 = append one CRC-8 beat after the data
GAP_CYCLES, 2, minimum number of idle cycles (m_axis_tvalid=0) between frames; 0 is allowed

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cfg_preamble_len  in  CNT_W  preamble beat count, sampled at frame start
s_axis_tdata  in  DATA_WIDTH  payload
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  payload ready
s_axis_tlast  in  1  last payload beat
m_axis_tdata  out  DATA_WIDTH  framed stream
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of the frame
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse when the final beat of a frame is accepted

Behaviour:
- Reset is asynchronous, active-low, and applies to all state.
  - Outputs at reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, busy=0, frame_done=0.
  - The state machine returns to IDLE and the counters and CRC clear to 0.
  - A reset mid-frame abandons the frame. There is no recovery and no partial tlast.
- The output is a single register stage.
  - slot_free = !m_axis_tvalid || m_axis_tready.
  - The register loads only when slot_free is high.
  - tdata and tlast are held stable while tvalid=1 and tready=0 (AXI rule).
- States:
  - IDLE: waits for s_axis_tvalid. Payload is not consumed in IDLE. When s_axis_tvalid=1, latch cfg_preamble_len into the counter and clear the CRC. If the latched length is 0, go to SFD; otherwise go to PRE. The first framing beat is valid on the next cycle.
  - PRE: on each slot_free, load PREAMBLE_PATTERN with tlast=0 and decrement the counter. On the load that takes the count from 1 to 0, the next slot_free loads SFD_WORD (SFD state).
  - SFD: on slot_free, load SFD_WORD with tlast=0, then go to DATA.
  - DATA: s_axis_tready = slot_free. On s_axis_tvalid && s_axis_tready, load s_axis_tdata and update the CRC.
    - If s_axis_tlast=1 and APPEND_CRC=0, set m_axis_tlast=1 and go to FLUSH.
    - If s_axis_tlast=1 and APPEND_CRC=1, set tlast=0 and go to CRC.
    - If slot_free=1 but s_axis_tvalid=0, m_axis_tvalid drops to 0. A source bubble is passed through and the frame is not aborted.
  - CRC: on slot_free, load the final CRC (zero-extended to DATA_WIDTH) with tlast=1, then go to FLUSH.
  - FLUSH: wait until the tlast beat is accepted (m_axis_tvalid && m_axis_tready && m_axis_tlast). In that cycle, pulse frame_done, load the gap counter with GAP_CYCLES, and go to GAP (or to IDLE if GAP_CYCLES=0).
  - GAP: m_axis_tvalid=0. Decrement the counter each cycle and go to IDLE when it reaches 0. s_axis_tready=0 throughout.
- s_axis_tready is 0 in every state except DATA.
- CRC-8:
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Each accepted DATA_WIDTH word is processed MSB-first.
  - The CRC covers payload only, not the preamble or SFD.
- A change to cfg_preamble_len mid-frame has no effect until the next IDLE sample.
- Single-beat payload (tvalid and tlast in the first DATA beat) is legal.
- Throughput with tready held at 1: the frame occupies 1 + N + 1 + L (+1 if APPEND_CRC) cycles from IDLE detection, followed by GAP_CYCLES idle cycles.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PRE, SFD, DATA, CRC, FLUSH, GAP), 3 bits;
  - CRC8_POLY = 8'h07;
  - default PREAMBLE_PATTERN and SFD constants, for reuse by the receive-side SFD detector.
- Sub-module: crc8_word, a combinational next-CRC function of (crc_in, data word), parametrised by DATA_WIDTH. It is shared with the receiver checker.

Test Plan:
- DATA_WIDTH=8, cfg_preamble_len=2, APPEND_CRC=0, tready=1, payload 11,22,33(tlast) -> output AA,AA,D5,11,22,33(tlast) on consecutive cycles; frame_done pulses once; 2 idle cycles follow.
- cfg_preamble_len=0, single beat 5A(tlast) -> D5,5A(tlast); s_axis_tready high for exactly one cycle.
- APPEND_CRC=1, payload 01,02(tlast), preamble 1 -> AA,D5,01,02,CRC(tlast)=0x1B (CRC-8/0x07 over 01 02); the CRC beat carries tlast and 02 does not.
- Random m_axis_tready backpressure (~50%) over 100 frames of random length 1–16 -> tdata/tlast stable while stalled; no lost or duplicated beats; scoreboard matches.
- Source bubbles (s_axis_tvalid toggling) in DATA plus cfg_preamble_len changed mid-frame -> frame contents unaffected; the new length applies to the next frame only.
- aresetn asserted mid-DATA (asynchronously, between clock edges) -> outputs go to 0 immediately; after release, the next frame starts cleanly from preamble with the CRC reset.

Source files
------------

// File: rtl/axis_frame_preamble_gen_pkg.sv
// Shared framing constants: FSM encoding, CRC-8 polynomial and default preamble/SFD bytes.
// Also consumed by the receive-side SFD detector and CRC checker.
package axis_frame_preamble_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PRE   = 3'd1;
  localparam state_t ST_SFD   = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_CRC   = 3'd4;
  localparam state_t ST_FLUSH = 3'd5;
  localparam state_t ST_GAP   = 3'd6;

  localparam logic [7:0] CRC8_POLY     = 8'h07;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/axis_frame_preamble_gen_if.sv
// AXI-Stream beat bundle (data, valid, ready, last) shared by the framer's input and output.
// master drives the beat, slave returns ready.
interface axis_frame_preamble_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_preamble_gen_crc8_word.sv
// Combinational CRC-8 step over one DATA_WIDTH word, MSB first, no reflection.
// Zero latency; shared with the receive-side checker.
module axis_frame_preamble_gen_crc8_word
  import axis_frame_preamble_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [7:0]            crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [7:0]            crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (c[7] ^ data[i]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/axis_frame_preamble_gen.sv
// Frames each packet as preamble x N, SFD, payload, optional CRC-8, then a minimum idle gap.
// One output register stage; loads only when the slot is free, so downstream stalls hold the beat and stall the source.
module axis_frame_preamble_gen
  import axis_frame_preamble_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 8,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_PATTERN = {(DATA_WIDTH / 8){PREAMBLE_BYTE}},
  parameter logic [DATA_WIDTH-1:0] SFD_WORD         = DATA_WIDTH'(SFD_BYTE),
  parameter int                    CNT_W            = 4,
  parameter bit                    APPEND_CRC       = 1'b0,
  parameter int                    GAP_CYCLES       = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNT_W-1:0]      cfg_preamble_len,
  axis_frame_preamble_gen_if.slave  s_axis,
  axis_frame_preamble_gen_if.master m_axis,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t                state;
  logic [CNT_W-1:0]      pre_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [7:0]            crc;
  logic [7:0]            crc_nxt;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld;
  logic                  out_lst;
  logic                  slot_free;
  logic                  s_hs;
  logic                  m_last_hs;

  assign slot_free     = !out_vld || m_axis.tready;
  assign s_axis.tready = (state == ST_DATA) && slot_free;
  assign s_hs          = s_axis.tvalid && s_axis.tready;
  assign m_last_hs     = out_vld && m_axis.tready && out_lst;

  assign m_axis.tdata  = out_dat;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_lst;
  assign busy          = (state != ST_IDLE);
  assign frame_done    = (state == ST_FLUSH) && m_last_hs;

  axis_frame_preamble_gen_crc8_word #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_crc8 (
    .crc_in  (crc),
    .data    (s_axis.tdata),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      pre_cnt <= '0;
      gap_cnt <= '0;
      crc     <= '0;
      out_dat <= '0;
      out_vld <= 1'b0;
      out_lst <= 1'b0;
    end else begin
      case (state)
        // The first framing beat is loaded on the detection edge itself so the
        // frame runs without a bubble; pre_cnt holds preamble beats still owed.
        ST_IDLE: begin
          if (s_axis.tvalid && slot_free) begin
            crc     <= '0;
            out_vld <= 1'b1;
            out_lst <= 1'b0;
            if (cfg_preamble_len == '0) begin
              out_dat <= SFD_WORD;
              pre_cnt <= '0;
              state   <= ST_DATA;
            end else begin
              out_dat <= PREAMBLE_PATTERN;
              pre_cnt <= cfg_preamble_len - CNT_W'(1);
              state   <= (cfg_preamble_len == CNT_W'(1)) ? ST_SFD : ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (slot_free) begin
            out_vld <= 1'b1;
            out_dat <= PREAMBLE_PATTERN;
            out_lst <= 1'b0;
            pre_cnt <= pre_cnt - CNT_W'(1);
            if (pre_cnt == CNT_W'(1)) state <= ST_SFD;
          end
        end
        ST_SFD: begin
          if (slot_free) begin
            out_vld <= 1'b1;
            out_dat <= SFD_WORD;
            out_lst <= 1'b0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_hs) begin
            out_vld <= 1'b1;
            out_dat <= s_axis.tdata;
            crc     <= crc_nxt;
            if (s_axis.tlast) begin
              out_lst <= !APPEND_CRC;
              state   <= APPEND_CRC ? ST_CRC : ST_FLUSH;
            end else begin
              out_lst <= 1'b0;
            end
          end else if (slot_free) begin
            // Source bubble: pass the idle through rather than abort the frame.
            out_vld <= 1'b0;
          end
        end
        ST_CRC: begin
          if (slot_free) begin
            out_vld <= 1'b1;
            out_dat <= DATA_WIDTH'(crc);
            out_lst <= 1'b1;
            state   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (m_last_hs) begin
            out_vld <= 1'b0;
            out_lst <= 1'b0;
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_preamble_gen.sv
// Scoreboard bench: dut0 without CRC trailer, dut1 with CRC trailer, both GAP_CYCLES=2.
// Stimulus pushes expected beats; a negedge monitor pops and compares on every accepted output beat.
module tb_axis_frame_preamble_gen;

  localparam int GAP = 2;

  logic       aclk;
  logic       aresetn;
  logic [1:0] s_vld, s_lst, m_rdy, bp, mon_en;
  logic [7:0] s_dat [2];
  logic [3:0] cfg [2];
  wire  [1:0] s_rdy, m_vld, m_lst, busy, fdone;
  wire  [7:0] m_dat [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  axis_frame_preamble_gen_if #(.DATA_WIDTH(8)) s0 ();
  axis_frame_preamble_gen_if #(.DATA_WIDTH(8)) m0 ();
  axis_frame_preamble_gen_if #(.DATA_WIDTH(8)) s1 ();
  axis_frame_preamble_gen_if #(.DATA_WIDTH(8)) m1 ();

  assign s0.tdata  = s_dat[0];
  assign s0.tvalid = s_vld[0];
  assign s0.tlast  = s_lst[0];
  assign s_rdy[0]  = s0.tready;
  assign m0.tready = m_rdy[0];
  assign m_dat[0]  = m0.tdata;
  assign m_vld[0]  = m0.tvalid;
  assign m_lst[0]  = m0.tlast;

  assign s1.tdata  = s_dat[1];
  assign s1.tvalid = s_vld[1];
  assign s1.tlast  = s_lst[1];
  assign s_rdy[1]  = s1.tready;
  assign m1.tready = m_rdy[1];
  assign m_dat[1]  = m1.tdata;
  assign m_vld[1]  = m1.tvalid;
  assign m_lst[1]  = m1.tlast;

  axis_frame_preamble_gen #(
    .DATA_WIDTH(8), .CNT_W(4), .APPEND_CRC(1'b0), .GAP_CYCLES(GAP)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_preamble_len(cfg[0]),
    .s_axis(s0), .m_axis(m0), .busy(busy[0]), .frame_done(fdone[0])
  );

  axis_frame_preamble_gen #(
    .DATA_WIDTH(8), .CNT_W(4), .APPEND_CRC(1'b1), .GAP_CYCLES(GAP)
  ) u_dut_crc (
    .aclk(aclk), .aresetn(aresetn), .cfg_preamble_len(cfg[1]),
    .s_axis(s1), .m_axis(m1), .busy(busy[1]), .frame_done(fdone[1])
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [7:0] pay [16];

  int         idle_run [2];
  int         first_cyc [2];
  int         done_cyc [2];
  int         rdy_cnt [2];
  int         gap_busy [2];
  bit         in_frame [2];
  bit         had_frame [2];
  bit         prev_stall [2];
  bit         gap_on [2];
  logic [8:0] prev_beat [2];
  logic [8:0] last_beat [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void q_push(input int d, input logic [8:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] q_pop(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Reference CRC-8/0x07 in the byte-wise form: xor the byte in, then 8 shifts.
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  task automatic mon(input int d);
    logic [8:0] beat;
    bit         hs;
    if (!aresetn || !mon_en[d]) begin
      prev_stall[d] = 0; in_frame[d] = 0; had_frame[d] = 0; gap_on[d] = 0;
      return;
    end
    beat = {m_lst[d], m_dat[d]};
    hs   = m_vld[d] && m_rdy[d];
    if (s_rdy[d]) rdy_cnt[d]++;
    if (prev_stall[d]) begin
      chk($sformatf("stall_vld%0d", d), m_vld[d], 1);
      chk($sformatf("stall_hold%0d", d), beat, prev_beat[d]);
    end
    chk($sformatf("frame_done%0d", d), fdone[d], hs && m_lst[d]);
    if (gap_on[d]) begin
      if (busy[d]) gap_busy[d]++; else gap_on[d] = 0;
    end
    if (m_vld[d] && !in_frame[d]) begin
      in_frame[d]  = 1;
      first_cyc[d] = cyc;
      if (had_frame[d]) chk($sformatf("gap_idle%0d", d), idle_run[d] >= GAP, 1);
    end
    if (hs) begin
      if (q_size(d) == 0) fail($sformatf("extra_beat%0d got=%0h", d, beat));
      else chk($sformatf("beat%0d", d), beat, q_pop(d));
      if (m_lst[d]) begin
        in_frame[d] = 0; had_frame[d] = 1; done_cyc[d] = cyc; last_beat[d] = beat;
        idle_run[d] = 0; gap_on[d] = 1; gap_busy[d] = 0;
      end
    end else if (!m_vld[d]) begin
      idle_run[d]++;
    end
    prev_stall[d] = m_vld[d] && !m_rdy[d];
    prev_beat[d]  = beat;
  endtask

  always @(negedge aclk) begin
    mon(0);
    mon(1);
  end

  initial begin
    m_rdy = 2'b11;
    forever begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < 2; d++) m_rdy[d] = bp[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_hs(input int d, output bit ok);
    bit seen;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      seen = s_rdy[d];
      @(posedge aclk);
      #1;
      if (seen) begin
        ok = 1;
        return;
      end
    end
    fail($sformatf("hs_timeout%0d", d));
  endtask

  // plen < 0 keeps the current cfg; cfg_mid >= 0 is written after the first payload beat.
  task automatic send_frame(input int d, input int plen, input int n, input bit bub, input int cfg_mid);
    logic [7:0] c;
    bit         ok;
    int         pl;
    if (plen >= 0) cfg[d] = 4'(plen);
    pl = int'(cfg[d]);
    c  = 8'h00;
    for (int i = 0; i < pl; i++) q_push(d, {1'b0, 8'hAA});
    q_push(d, {1'b0, 8'hD5});
    for (int i = 0; i < n; i++) begin
      c = crc_upd(c, pay[i]);
      q_push(d, {(d == 0) && (i == n - 1), pay[i]});
    end
    if (d == 1) q_push(d, {1'b1, c});
    for (int i = 0; i < n; i++) begin
      if (bub && (i % 2 == 1)) begin
        s_vld[d] = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
      end
      s_dat[d] = pay[i];
      s_lst[d] = (i == n - 1);
      s_vld[d] = 1'b1;
      wait_hs(d, ok);
      if (!ok) break;
      if (i == 0 && cfg_mid >= 0) cfg[d] = 4'(cfg_mid);
    end
    s_vld[d] = 1'b0;
    s_lst[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    for (int k = 0; k < 5000; k++) begin
      if (q_size(d) == 0 && !m_vld[d]) break;
      @(posedge aclk);
      #1;
    end
    chk($sformatf("drain%0d", d), q_size(d), 0);
    repeat (5) @(posedge aclk);
    #1;
  endtask

  initial begin
    int t0;
    aresetn = 1'b0;
    s_vld = '0; s_lst = '0; bp = '0; mon_en = 2'b11;
    s_dat[0] = '0; s_dat[1] = '0; cfg[0] = '0; cfg[1] = '0;
    repeat (3) @(posedge aclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tvalid", m_vld[d], 0);
      chk("rst_tdata", m_dat[d], 0);
      chk("rst_tlast", m_lst[d], 0);
      chk("rst_s_tready", s_rdy[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_frame_done", fdone[d], 0);
    end
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Preamble 2, payload 11 22 33 back-to-back.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    t0 = cyc;
    send_frame(0, 2, 3, 0, -1);
    wait_drain(0);
    chk("t1_latency", first_cyc[0] - t0, 1);
    chk("t1_span", done_cyc[0] - first_cyc[0], 5);
    chk("t1_gap_busy", gap_busy[0], GAP);

    // Zero preamble, single beat payload.
    rdy_cnt[0] = 0;
    pay[0] = 8'h5A;
    t0 = cyc;
    send_frame(0, 0, 1, 0, -1);
    wait_drain(0);
    chk("t2_latency", first_cyc[0] - t0, 1);
    chk("t2_span", done_cyc[0] - first_cyc[0], 1);
    chk("t2_s_tready_cycles", rdy_cnt[0], 1);

    // CRC trailer over 01 02 is 0x1B.
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_frame(1, 1, 2, 0, -1);
    wait_drain(1);
    chk("t3_crc_beat", last_beat[1], {1'b1, 8'h1B});

    // Source bubbles with cfg changed mid-frame; new length only on the next frame.
    for (int i = 0; i < 8; i++) pay[i] = 8'h10 + 8'(i);
    send_frame(0, 3, 8, 1, 1);
    for (int i = 0; i < 2; i++) pay[i] = 8'hC0 + 8'(i);
    send_frame(0, -1, 2, 1, -1);
    wait_drain(0);

    // Random lengths under ~50% downstream backpressure.
    bp[0] = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      send_frame(0, $urandom_range(0, 15), n, 1'($urandom_range(0, 1)), -1);
    end
    wait_drain(0);
    bp[0] = 1'b0;
    bp[1] = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      send_frame(1, $urandom_range(0, 15), n, 1'($urandom_range(0, 1)), -1);
    end
    wait_drain(1);
    bp[1] = 1'b0;

    // Asynchronous reset in the middle of DATA on the CRC instance.
    mon_en[1] = 1'b0;
    cfg[1] = 4'd1; s_dat[1] = 8'h77; s_lst[1] = 1'b0; s_vld[1] = 1'b1;
    repeat (5) @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("t6_tvalid", m_vld[1], 0);
    chk("t6_tdata", m_dat[1], 0);
    chk("t6_tlast", m_lst[1], 0);
    chk("t6_s_tready", s_rdy[1], 0);
    chk("t6_busy", busy[1], 0);
    s_vld[1] = 1'b0;
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    mon_en[1] = 1'b1;
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_frame(1, 1, 2, 0, -1);
    wait_drain(1);
    chk("t6_crc_after_reset", last_beat[1], {1'b1, 8'h1B});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
